// File: rtl/sram_arbiter.sv
// Two-client round-robin arbiter that serialises word read/write requests onto
// a level-sensitive SRAM controller command interface, with a completion watchdog.
module sram_arbiter #(
    parameter int AW      = 20,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_ack,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_ack,
    output logic [DW-1:0] c1_rdata,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic          ram_done,
    input  logic [DW-1:0] ram_rdata,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          gnt_q, gnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q;
    logic          ram_read_q, ram_read_d;
    logic          ram_write_q, ram_write_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          c0_ack_q, c0_ack_d;
    logic          c1_ack_q, c1_ack_d;
    logic [DW-1:0] c0_rdata_q, c0_rdata_d;
    logic [DW-1:0] c1_rdata_q, c1_rdata_d;
    logic          timeout_err_q, timeout_err_d;

    logic done_edge;
    logic pick;
    logic pick_we;

    // A done level left high by the previous transaction must not complete this one.
    assign done_edge = ram_done & ~done_q;
    assign pick      = (c0_req & c1_req) ? ~rr_ptr_q : c1_req;
    assign pick_we   = pick ? c1_we : c0_we;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        timer_d       = timer_q;
        ram_read_d    = ram_read_q;
        ram_write_d   = ram_write_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        c0_ack_d      = 1'b0;
        c1_ack_d      = 1'b0;
        c0_rdata_d    = c0_rdata_q;
        c1_rdata_d    = c1_rdata_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (c0_req | c1_req) begin
                    gnt_d       = pick;
                    rr_ptr_d    = pick;
                    ram_addr_d  = pick ? c1_addr : c0_addr;
                    ram_wdata_d = pick ? c1_wdata : c0_wdata;
                    ram_read_d  = ~pick_we;
                    ram_write_d = pick_we;
                    timer_d     = '0;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                timer_d = timer_q + TW'(1);
                if (done_edge) begin
                    if (ram_read_q) begin
                        if (gnt_q) c1_rdata_d = ram_rdata;
                        else       c0_rdata_d = ram_rdata;
                    end
                    ram_read_d  = 1'b0;
                    ram_write_d = 1'b0;
                    c0_ack_d    = ~gnt_q;
                    c1_ack_d    = gnt_q;
                    state_d     = S_ACK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Abort: the client still gets its ack so it never stalls forever.
                    ram_read_d    = 1'b0;
                    ram_write_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    c0_ack_d      = ~gnt_q;
                    c1_ack_d      = gnt_q;
                    state_d       = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= 1'b1;
            gnt_q         <= 1'b0;
            timer_q       <= '0;
            done_q        <= 1'b0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            c0_ack_q      <= 1'b0;
            c1_ack_q      <= 1'b0;
            c0_rdata_q    <= '0;
            c1_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            timer_q       <= timer_d;
            done_q        <= ram_done;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            c0_ack_q      <= c0_ack_d;
            c1_ack_q      <= c1_ack_d;
            c0_rdata_q    <= c0_rdata_d;
            c1_rdata_q    <= c1_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign c0_ack      = c0_ack_q;
    assign c1_ack      = c1_ack_q;
    assign c0_rdata    = c0_rdata_q;
    assign c1_rdata    = c1_rdata_q;
    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM controller model,
// reference memory and fairness model, one task per scenario.
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c0_req = 1'b0, c0_we = 1'b0;
    logic [AW-1:0] c0_addr = '0;
    logic [DW-1:0] c0_wdata = '0;
    logic          c1_req = 1'b0, c1_we = 1'b0;
    logic [AW-1:0] c1_addr = '0;
    logic [DW-1:0] c1_wdata = '0;
    logic          c0_ack, c1_ack;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_done = 1'b0;
    logic [DW-1:0] ram_rdata = '0;
    logic          timeout_err;
    logic [1:0]    dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_done(ram_done), .ram_rdata(ram_rdata),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ---------------- memories ----------------
    logic [DW-1:0] ctl_mem [int];
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hA5000000 ^ (a * 32'h9E3779B1);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- SRAM controller model ----------------
    // ctl_delay = N: done rises in the Nth cycle the command is high (0 = never).
    // ctl_hold: done stays high after completion and only falls in the 2nd command cycle.
    int ctl_delay = 4;
    bit ctl_hold  = 1'b0;
    int ctl_cnt   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            ctl_cnt  = 0;
            ram_done = 1'b0;
        end else if (ram_read || ram_write) begin
            ctl_cnt++;
            if (ctl_delay != 0 && ctl_cnt == ctl_delay) begin
                ram_done = 1'b1;
                if (ram_read)
                    ram_rdata = ctl_mem.exists(int'(ram_addr)) ? ctl_mem[int'(ram_addr)]
                                                                : init_word(int'(ram_addr));
                else
                    ctl_mem[int'(ram_addr)] = ram_wdata;
            end else begin
                ram_rdata = $urandom;
                if (!(ctl_hold && ctl_cnt == 1)) ram_done = 1'b0;
            end
        end else begin
            ctl_cnt = 0;
            if (!ctl_hold) ram_done = 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    int            rd_hi = 0, wr_hi = 0, both_ack = 0, unstable = 0;
    logic [AW-1:0] mon_addr = '0;
    logic [DW-1:0] mon_wdata = '0;
    bit            mon_prev_cmd = 1'b0;
    int            ack_log[$];

    always @(negedge clk) begin
        if (c0_ack && c1_ack) both_ack++;
        if (c0_ack) ack_log.push_back(0);
        if (c1_ack) ack_log.push_back(1);
        if (ram_read) rd_hi++;
        if (ram_write) wr_hi++;
        if (ram_read || ram_write) begin
            if (mon_prev_cmd && (ram_addr !== mon_addr || ram_wdata !== mon_wdata)) unstable++;
            mon_addr  = ram_addr;
            mon_wdata = ram_wdata;
        end
        mon_prev_cmd = ram_read || ram_write;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_hi = 0; wr_hi = 0; both_ack = 0; unstable = 0;
        ack_log.delete();
    endtask

    task automatic drive(input int cl, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (cl == 0) begin
            c0_req = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d;
        end else begin
            c1_req = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d;
        end
    endtask

    task automatic drop(input int cl);
        if (cl == 0) c0_req = 1'b0;
        else         c1_req = 1'b0;
    endtask

    task automatic wait_ack(input int cl, input int budget, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if ((cl == 0) ? c0_ack : c1_ack) seen = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick();
        tick();
        vec_cnt++;
        if ({c0_ack, c1_ack, ram_read, ram_write, timeout_err} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b expected 00000", {c0_ack, c1_ack, ram_read, ram_write, timeout_err});
        end
        vec_cnt++;
        if (c0_rdata !== '0 || c1_rdata !== '0) begin
            err_cnt++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", c0_rdata, c1_rdata);
        end
        vec_cnt++;
        if (ram_addr !== '0 || ram_wdata !== '0) begin
            err_cnt++;
            $display("FAIL reset_bus: got %h/%h expected 0/0", ram_addr, ram_wdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_c0();
        bit seen; int cyc;
        ctl_mem[32'h10] = 32'hDEADBEEF;
        ref_mem[32'h10] = 32'hDEADBEEF;
        ctl_delay = 6;
        clear_mon();
        drive(0, 1'b0, 20'h00010, 32'h0);
        wait_ack(0, 40, seen, cyc);
        drop(0);
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL read_c0_ack: got none expected ack within 40 cycles");
        end
        vec_cnt++;
        if (c0_rdata !== ref_rd(32'h10)) begin
            err_cnt++;
            $display("FAIL read_c0_rdata: got %h expected %h", c0_rdata, ref_rd(32'h10));
        end
        vec_cnt++;
        if (rd_hi != 6 || wr_hi != 0) begin
            err_cnt++;
            $display("FAIL read_c0_cmd_cycles: got rd=%0d wr=%0d expected rd=6 wr=0", rd_hi, wr_hi);
        end
        tick();
        vec_cnt++;
        if (c0_ack !== 1'b0 || c0_rdata !== 32'hDEADBEEF) begin
            err_cnt++;
            $display("FAIL read_c0_pulse: got ack=%b rdata=%h expected ack=0 rdata=deadbeef", c0_ack, c0_rdata);
        end
        tick();
        vec_cnt++;
        if (ack_log.size() != 1 || ack_log[0] != 0) begin
            err_cnt++;
            $display("FAIL read_c0_acklog: got %0d acks expected exactly one c0 ack", ack_log.size());
        end
    endtask

    task automatic test_write_c1();
        bit seen; int cyc;
        logic [DW-1:0] prev;
        prev = c1_rdata;
        ctl_delay = 5;
        clear_mon();
        drive(1, 1'b1, 20'hFFFFF, 32'h12345678);
        wait_ack(1, 40, seen, cyc);
        drop(1);
        ref_mem[32'hFFFFF] = 32'h12345678;
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL write_c1_ack: got none expected ack within 40 cycles");
        end
        vec_cnt++;
        if (wr_hi != 5 || rd_hi != 0 || unstable != 0) begin
            err_cnt++;
            $display("FAIL write_c1_cmd: got wr=%0d rd=%0d unstable=%0d expected 5/0/0", wr_hi, rd_hi, unstable);
        end
        vec_cnt++;
        if (mon_addr !== 20'hFFFFF || mon_wdata !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL write_c1_bus: got %h/%h expected fffff/12345678", mon_addr, mon_wdata);
        end
        vec_cnt++;
        if (c1_rdata !== prev) begin
            err_cnt++;
            $display("FAIL write_c1_rdata: got %h expected %h", c1_rdata, prev);
        end
        tick();
        vec_cnt++;
        if (!ctl_mem.exists(32'hFFFFF) || ctl_mem[32'hFFFFF] !== ref_rd(32'hFFFFF) || ack_log.size() != 1) begin
            err_cnt++;
            $display("FAIL write_c1_mem: got acks=%0d expected stored 12345678 and one ack", ack_log.size());
        end
    endtask

    task automatic test_stale_done();
        bit seen; int cyc;
        ctl_hold = 1'b1;
        ctl_delay = 3;
        drive(0, 1'b0, 20'h00010, 32'h0);
        wait_ack(0, 40, seen, cyc);
        drop(0);
        tick();
        clear_mon();
        ctl_delay = 6;
        ctl_mem[32'h22] = 32'hCAFE0022;
        ref_mem[32'h22] = 32'hCAFE0022;
        drive(1, 1'b0, 20'h00022, 32'h0);
        wait_ack(1, 40, seen, cyc);
        drop(1);
        vec_cnt++;
        if (!seen || rd_hi != 6) begin
            err_cnt++;
            $display("FAIL stale_done_cycles: got seen=%0d rd=%0d expected seen=1 rd=6", seen, rd_hi);
        end
        vec_cnt++;
        if (c1_rdata !== ref_rd(32'h22)) begin
            err_cnt++;
            $display("FAIL stale_done_rdata: got %h expected %h", c1_rdata, ref_rd(32'h22));
        end
        ctl_hold = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit seen; int cyc;
        logic [DW-1:0] prev;
        prev = c0_rdata;
        vec_cnt++;
        if (timeout_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_pre: got %b expected 0", timeout_err);
        end
        ctl_delay = 0;
        clear_mon();
        drive(0, 1'b0, 20'h00033, 32'h0);
        wait_ack(0, 60, seen, cyc);
        drop(0);
        vec_cnt++;
        if (!seen || rd_hi != TIMEOUT) begin
            err_cnt++;
            $display("FAIL timeout_cycles: got seen=%0d rd=%0d expected seen=1 rd=%0d", seen, rd_hi, TIMEOUT);
        end
        vec_cnt++;
        if (timeout_err !== 1'b1 || c0_rdata !== prev) begin
            err_cnt++;
            $display("FAIL timeout_flag: got err=%b rdata=%h expected err=1 rdata=%h", timeout_err, c0_rdata, prev);
        end
        ctl_delay = 3;
        tick();
        drive(0, 1'b0, 20'h00010, 32'h0);
        wait_ack(0, 40, seen, cyc);
        drop(0);
        tick();
        vec_cnt++;
        if (!seen || timeout_err !== 1'b1 || c0_rdata !== ref_rd(32'h10)) begin
            err_cnt++;
            $display("FAIL timeout_sticky: got seen=%0d err=%b rdata=%h expected 1/1/%h", seen, timeout_err, c0_rdata, ref_rd(32'h10));
        end
    endtask

    task automatic test_simultaneous();
        bit            pwe[2];
        int            paddr[2];
        logic [DW-1:0] pwd[2];
        int last, exp_id, got;
        pulse_reset();
        clear_mon();
        last = 1;
        for (int c = 0; c < 2; c++) begin
            pwe[c] = 1'($urandom_range(0, 1));
            paddr[c] = $urandom_range(0, 7);
            pwd[c] = $urandom;
        end
        ctl_delay = $urandom_range(1, 8);
        // Both requests rise in the same cycle.
        drive(0, pwe[0], AW'(paddr[0]), pwd[0]);
        drive(1, pwe[1], AW'(paddr[1]), pwd[1]);
        for (int k = 0; k < 12; k++) begin
            got = -1;
            for (int i = 0; i < 40 && got < 0; i++) begin
                tick();
                if (c0_ack) got = 0;
                else if (c1_ack) got = 1;
            end
            exp_id = 1 - last;
            last = exp_id;
            vec_cnt++;
            if (got != exp_id) begin
                err_cnt++;
                $display("FAIL rr_order[%0d]: got client %0d expected client %0d", k, got, exp_id);
                break;
            end
            if (pwe[got]) begin
                ref_mem[paddr[got]] = pwd[got];
            end else begin
                vec_cnt++;
                if (((got == 0) ? c0_rdata : c1_rdata) !== ref_rd(paddr[got])) begin
                    err_cnt++;
                    $display("FAIL rr_rdata[%0d]: got %h expected %h", k,
                             (got == 0) ? c0_rdata : c1_rdata, ref_rd(paddr[got]));
                end
            end
            pwe[got] = 1'($urandom_range(0, 1));
            paddr[got] = $urandom_range(0, 7);
            pwd[got] = $urandom;
            ctl_delay = $urandom_range(1, 8);
            drive(got, pwe[got], AW'(paddr[got]), pwd[got]);
        end
        drop(0);
        drop(1);
        // Let any transaction already granted finish and keep the reference in step.
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c0_ack && pwe[0]) ref_mem[paddr[0]] = pwd[0];
            if (c1_ack && pwe[1]) ref_mem[paddr[1]] = pwd[1];
        end
        vec_cnt++;
        if (both_ack != 0) begin
            err_cnt++;
            $display("FAIL rr_overlap: got %0d overlapping acks expected 0", both_ack);
        end
    endtask

    task automatic test_back_to_back();
        int last_t, t, got_n;
        int addr;
        ctl_delay = 1;
        clear_mon();
        t = 0;
        last_t = -1;
        got_n = 0;
        addr = $urandom_range(0, 7);
        drive(1, 1'b0, AW'(addr), 32'h0);
        for (int i = 0; i < 40 && got_n < 4; i++) begin
            tick();
            t++;
            if (c1_ack) begin
                vec_cnt++;
                if (c1_rdata !== ref_rd(addr)) begin
                    err_cnt++;
                    $display("FAIL b2b_rdata[%0d]: got %h expected %h", got_n, c1_rdata, ref_rd(addr));
                end
                if (last_t >= 0) begin
                    vec_cnt++;
                    if (t - last_t != 3) begin
                        err_cnt++;
                        $display("FAIL b2b_interval[%0d]: got %0d cycles expected 3", got_n, t - last_t);
                    end
                end
                last_t = t;
                got_n++;
                addr = $urandom_range(0, 7);
                if (got_n < 4) drive(1, 1'b0, AW'(addr), 32'h0);
                else drop(1);
            end
        end
        vec_cnt++;
        if (got_n != 4 || ack_log.size() != 4 || ack_log.sum() != 4) begin
            err_cnt++;
            $display("FAIL b2b_count: got %0d acks expected 4 acks all to client 1", ack_log.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen; int cyc;
        ctl_delay = 0;
        drive(0, 1'b0, 20'h00044, 32'h0);
        tick();
        tick();
        tick();
        vec_cnt++;
        if (ram_read !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_pre: got ram_read=%b expected 1", ram_read);
        end
        rst = 1'b0;
        #1;
        vec_cnt++;
        if ({ram_read, ram_write, c0_ack, c1_ack, timeout_err} !== 5'b0 || ram_addr !== '0 || c0_rdata !== '0) begin
            err_cnt++;
            $display("FAIL rstmid_async: got flags=%b addr=%h rdata=%h expected all 0",
                     {ram_read, ram_write, c0_ack, c1_ack, timeout_err}, ram_addr, c0_rdata);
        end
        drop(0);
        tick();
        rst = 1'b1;
        clear_mon();
        for (int i = 0; i < 20; i++) tick();
        vec_cnt++;
        if (ack_log.size() != 0 || rd_hi != 0) begin
            err_cnt++;
            $display("FAIL rstmid_noack: got acks=%0d rd=%0d expected 0/0", ack_log.size(), rd_hi);
        end
        ctl_delay = 4;
        drive(1, 1'b0, 20'h00010, 32'h0);
        wait_ack(1, 40, seen, cyc);
        drop(1);
        vec_cnt++;
        if (!seen || c1_rdata !== ref_rd(32'h10) || rd_hi != 4) begin
            err_cnt++;
            $display("FAIL rstmid_after: got seen=%0d rdata=%h rd=%0d expected 1/%h/4", seen, c1_rdata, rd_hi, ref_rd(32'h10));
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_read_c0();
        test_write_c1();
        test_stale_done();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-client arbiter and sequencer in front of the SRAM controller.
- Accepts word read/write requests from two requesters, e.g. the sample playback engine (client 0) and the sample loader/CPU (client 1).
- Serialises requests onto the controller's level-sensitive read/write command inputs and returns read data plus a one-cycle acknowledge to the winner.
- Round-robin fairness; watchdog on the controller's completion flag.

Parameters:
AW, 20, address width (matches SRAM address bus)
DW, 32, data width
TIMEOUT, 15, max cycles to wait for ram_done rising edge before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
c0_req  in  1  client 0 request; held high with fields stable until c0_ack
c0_we  in  1  client 0: 1 = write, 0 = read
c0_addr  in  AW  client 0 word address
c0_wdata  in  DW  client 0 write data
c0_ack  out  1  client 0 one-cycle completion pulse
c0_rdata  out  DW  client 0 read data, valid in the c0_ack cycle and held until next c0 read completes
c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rdata  same as client 0, for client 1
ram_read  out  1  read command level to controller
ram_write  out  1  write command level to controller
ram_addr  out  AW  address to controller
ram_wdata  out  DW  write data to controller
ram_done  in  1  controller completion flag (level; may stay high between transactions)
ram_rdata  in  DW  controller read data, valid when ram_done rises
timeout_err  out  1  sticky: a transaction timed out

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, all outputs 0 (acks, rdata, ram_read/ram_write/ram_addr/ram_wdata, timeout_err).
  - rr_ptr=1, so client 0 wins the first tie.
  - done_q=0, timer=0. Any in-flight transaction is dropped with no ack.
- All outputs are registered.
- done_q: ram_done delayed one clk. done_edge = ram_done & ~done_q.
  - Completion is done_edge only; a ram_done level left high from the previous transaction is ignored.
- States: IDLE, CMD, ACK.
- IDLE:
  - Only one req high: grant that client.
  - Both high: grant ~rr_ptr.
  - On grant: latch addr/wdata into ram_addr/ram_wdata, assert ram_write if we=1 else ram_read, set rr_ptr=granted id, clear timer, go CMD.
  - No req: stay IDLE.
- CMD:
  - Hold ram_read/ram_write, ram_addr and ram_wdata stable. The controller samples the command level in several of its own states, so the command must not pulse.
  - timer increments each cycle.
  - On done_edge:
    - Read: copy ram_rdata into the granted client's rdata.
    - Drop ram_read/ram_write, assert the granted client's ack, go ACK.
  - Else if timer==TIMEOUT-1: drop the command, set timeout_err, assert ack (rdata unchanged), go ACK.
- ACK:
  - Ack high for exactly this one cycle, then cleared; go IDLE.
  - The client must drop or renew req at the edge ending the ack cycle.
  - IDLE samples requests from the following cycle, so a held req is treated as a new request.
- Latency:
  - req seen in IDLE at cycle N -> command high at N+1.
  - done_edge at cycle M -> ack and rdata at M+1 -> IDLE at M+2.
  - Minimum 3 cycles plus controller time per transaction.
- Both clients are never acked in the same cycle; only one transaction is outstanding at a time.
- Requests arriving during CMD/ACK wait; there is no queue beyond the req-hold rule.
- rr_ptr updates only on grant.
  - Continuous requests from both clients alternate 0,1,0,1.
  - A lone requester is served back-to-back.
- timeout_err clears only on reset.

Test Plan:
1. Read, client 0: c0 read addr 0x00010, model ram_done rises 6 cycles after ram_read -> ram_read high 6 cycles, c0_ack one pulse, c0_rdata=0xDEADBEEF, c1_ack stays 0.
2. Write, client 1: c1 write addr 0xFFFFF data 0x12345678 -> ram_write high, ram_addr=0xFFFFF, ram_wdata=0x12345678 stable until done edge; c1_ack pulse; c1_rdata unchanged.
3. Simultaneous requests: c0_req and c1_req rise the same cycle after reset, both re-requesting after each ack -> grant order 0,1,0,1; acks never overlap.
4. Stale done: ram_done stays high after a completion, new read issued, ram_done falls then rises 4 cycles later -> ack only after that rise, not on the stale level.
5. Timeout: ram_done held 0 -> command dropped after 15 cycles in CMD, ack pulses, timeout_err=1 and remains 1.
6. Reset mid-operation: rst low during CMD -> outputs 0 immediately; after release, no ack for the aborted request; a new c1 request is served normally.
